// File: rtl/if_id_stage_pkg.sv
// Shared types and constants for the IF stage and its IF/ID pipeline register.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int                 INSTR_W          = 16;
  localparam int                 DRAIN_CNT_W      = 8;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;
  localparam logic [3:0]         HALT_OP_DEFAULT  = 4'hF;
  localparam logic [INSTR_W-1:0] PC_INC           = 16'd2;

  function automatic logic [INSTR_W-1:0] pc_plus_inc(input logic [INSTR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_id_stage_if_id_reg.sv
// IF/ID pipeline register: bubble (NOP, invalid), load (new fetch) or hold.
module if_id_reg
  import if_id_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [INSTR_W-1:0] i_pc_plus2,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_pc_plus2,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_pc_plus2;
  logic               r_valid;

  // Bubble wins over load; PC+2 is left untouched by a bubble since it is meaningless then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_WORD;
      r_pc_plus2 <= 16'h0000;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr    <= NOP_WORD;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
      r_valid    <= 1'b1;
    end else begin
      r_instr    <= r_instr;
      r_pc_plus2 <= r_pc_plus2;
      r_valid    <= r_valid;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: next-PC selection, halt/drain FSM and the IF/ID register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD     = NOP_WORD_DEFAULT,
  parameter logic [3:0]         HALT_OP      = HALT_OP_DEFAULT,
  parameter int                 DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] PC,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [INSTR_W-1:0] BranchTarget,
  output logic [INSTR_W-1:0] NewPC,
  output logic               StopPC,
  output logic               Halt,
  output logic [INSTR_W-1:0] IfId_Instr,
  output logic [INSTR_W-1:0] IfId_PCPlus2,
  output logic               IfId_Valid
);

  state_e                 r_state;
  logic [DRAIN_CNT_W-1:0] r_cnt;
  logic                   r_halt;

  logic [INSTR_W-1:0] w_pc_plus2;
  logic               w_in_run;
  logic               w_in_drain;
  logic               w_in_halted;
  logic               w_halt_fetch;
  logic               w_load;
  logic               w_bubble;

  // Next-PC select, PC hold request and IF/ID control decode.
  always_comb begin
    w_pc_plus2   = pc_plus_inc(PC);
    w_in_run     = (r_state == ST_RUN);
    w_in_drain   = (r_state == ST_DRAIN);
    w_in_halted  = (r_state == ST_HALTED);
    w_halt_fetch = w_in_run & (Instr[15:12] == HALT_OP) & ~Stall & ~BranchTaken;
    if (BranchTaken) begin
      NewPC = BranchTarget;
    end else begin
      NewPC = w_pc_plus2;
    end
    StopPC   = ~BranchTaken & ((Stall & w_in_run) | w_in_drain);
    // HALTED freezes the register completely, even against a late redirect.
    w_bubble = ~w_in_halted & (BranchTaken | (~Stall & w_in_drain));
    w_load   = w_in_run & ~BranchTaken & ~Stall;
  end

  // Halt/drain FSM; a redirect while draining means the HALT was on a wrong path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 8'd0;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_fetch) begin
            r_state <= ST_DRAIN;
            r_cnt   <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (BranchTaken) begin
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
          end else if (r_cnt == 8'd0) begin
            r_state <= ST_HALTED;
            r_halt  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
          r_halt  <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 8'd0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign Halt = r_halt;

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_instr    (Instr),
    .i_pc_plus2 (w_pc_plus2),
    .o_instr    (IfId_Instr),
    .o_pc_plus2 (IfId_PCPlus2),
    .o_valid    (IfId_Valid)
  );

endmodule
